// File: rtl/hdlc_pkg.sv
// Shared constants and state encoding for the HDLC-style flag framer and detector.
package hdlc_pkg;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam int         STUFF_RUN = 5;
  localparam int         ABORT_LEN = 7;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    DATA,
    STUFF,
    CLOSE,
    ABORT
  } tx_state_t;

endpackage

// File: rtl/hdlc_bit_stuffer.sv
// Tracks the run of consecutive payload 1s and requests an inserted 0 once the
// run reaches STUFF_RUN. Flag, abort and stuff bits are not counted and clear the run.
module hdlc_bit_stuffer #(
  parameter int STUFF_RUN = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_strobe,
  input  logic flag_mode,
  output logic bit_out,
  output logic insert_zero
);

  localparam int            RW       = $clog2(STUFF_RUN + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(STUFF_RUN - 1);

  logic [RW-1:0] run_cnt;

  // Run counter: counts payload 1s, any payload 0 or non-payload cycle clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
    end else if (flag_mode) begin
      run_cnt <= '0;
    end else if (bit_strobe) begin
      run_cnt <= bit_in ? run_cnt + 1'b1 : '0;
    end
  end

  assign bit_out     = bit_in;
  assign insert_zero = bit_strobe & ~flag_mode & bit_in & (run_cnt == RUN_LAST);

endmodule

// File: rtl/hdlc_flag_tx.sv
// Flag-delimited serial framer: opening flag(s), zero-stuffed payload, closing flag,
// or an abort sequence of 1s when the source underruns mid-frame.
//
// state | meaning
// IDLE  | line idle at 1, waiting for the first byte of a frame
// OPEN  | shifting FLAG_BYTE OPEN_FLAGS times
// DATA  | shifting the held payload byte MSB-first
// STUFF | driving one inserted 0 after a run of STUFF_RUN payload 1s
// CLOSE | shifting one closing FLAG_BYTE
// ABORT | driving ABORT_LEN 1s after an underrun
module hdlc_flag_tx #(
  parameter logic [7:0] FLAG_BYTE  = hdlc_pkg::FLAG_BYTE,
  parameter int         STUFF_RUN  = hdlc_pkg::STUFF_RUN,
  parameter int         OPEN_FLAGS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       w,
  output logic       w_valid,
  output logic       busy
);

  import hdlc_pkg::*;

  localparam int            FW         = $clog2(OPEN_FLAGS + 1) + 3;
  localparam logic [FW-1:0] OPEN_LOAD  = FW'(8 * OPEN_FLAGS - 1);
  localparam logic [FW-1:0] CLOSE_LOAD = FW'(7);
  localparam logic [FW-1:0] ABORT_LOAD = FW'(ABORT_LEN - 1);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [7:0]    hold;
  logic          hold_last;
  logic [2:0]    bit_cnt;
  logic [FW-1:0] cnt;
  logic          byte_done;
  logic          cnt_tc;
  logic          accept;
  logic          byte_end;
  logic          bit_sel;
  logic          bit_strobe;
  logic          flag_mode;
  logic          stuf_bit;
  logic          insert_zero;
  logic          w_nxt;
  logic          w_valid_nxt;

  hdlc_bit_stuffer #(
    .STUFF_RUN (STUFF_RUN)
  ) u_stuffer (
    .clk         (clk),
    .reset_n     (reset_n),
    .bit_in      (bit_sel),
    .bit_strobe  (bit_strobe),
    .flag_mode   (flag_mode),
    .bit_out     (stuf_bit),
    .insert_zero (insert_zero)
  );

  assign cnt_tc     = (cnt == '0);
  assign accept     = din_valid & din_ready;
  assign bit_strobe = (state == DATA);
  assign flag_mode  = (state != DATA);
  // A byte finishes on its bit 0, or on the stuff bit that follows bit 0.
  assign byte_end   = ((state == DATA) && (bit_cnt == 3'd0) && !insert_zero) ||
                      ((state == STUFF) && byte_done);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = OPEN;
      end
      OPEN: begin
        if (cnt_tc) state_nxt = DATA;
      end
      DATA, STUFF: begin
        if (insert_zero) begin
          state_nxt = STUFF;
        end else if (byte_end) begin
          if (hold_last)   state_nxt = CLOSE;
          else if (accept) state_nxt = DATA;
          else             state_nxt = ABORT;
        end else begin
          state_nxt = DATA;
        end
      end
      CLOSE, ABORT: begin
        if (cnt_tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and handshake; din_ready never looks at din_valid.
  always_comb begin
    busy        = (state != IDLE);
    w_valid_nxt = (state != IDLE);
    w_nxt       = stuf_bit;
    din_ready   = 1'b0;
    if (state == IDLE) begin
      din_ready = 1'b1;
    end else if (byte_end && !hold_last) begin
      din_ready = 1'b1;
    end
  end

  // Bit offered to the stuffer for the next line edge.
  always_comb begin
    bit_sel = 1'b1;
    case (state)
      OPEN, CLOSE: bit_sel = FLAG_BYTE[cnt[2:0]];
      DATA:        bit_sel = hold[bit_cnt];
      STUFF:       bit_sel = 1'b0;
      default:     bit_sel = 1'b1;
    endcase
  end

  // Registered line output; reset forces the idle level at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w       <= 1'b1;
      w_valid <= 1'b0;
    end else begin
      w       <= w_nxt;
      w_valid <= w_valid_nxt;
    end
  end

  // Holding register and payload bit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_last <= 1'b0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= din;
        hold_last <= din_last;
        bit_cnt   <= 3'd7;
      end else if (state == DATA) begin
        bit_cnt <= bit_cnt - 3'd1;
      end
      if (state == DATA) begin
        byte_done <= (bit_cnt == 3'd0);
      end
    end
  end

  // Down-counter timing flag and abort sequences; low 3 bits index the flag MSB-first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if ((state == IDLE) && accept) begin
      cnt <= OPEN_LOAD;
    end else if ((state_nxt == CLOSE) && (state != CLOSE)) begin
      cnt <= CLOSE_LOAD;
    end else if ((state_nxt == ABORT) && (state != ABORT)) begin
      cnt <= ABORT_LOAD;
    end else if (!cnt_tc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
